// File: rtl/dac_spi_driver_if.sv
// Word handshake between the DSP/loopback datapath and dac_spi_driver.
// master: the producer of DAC codes; slave: the SPI driver.
interface dac_spi_driver_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              busy;
   logic              done;

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  busy,
      input  done
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output busy,
      output done
   );
endinterface

// File: rtl/dac_spi_driver.sv
// SPI write master for a 16-bit serial DAC (mode 0, MSB first).
// One word per valid/ready handshake is framed by CS_N and shifted on SDI/SCLK.
// Optional feature macro: DAC_LDAC_EN adds an LDAC_N low pulse after each frame
// and lengthens the inter-frame gap by LDAC_W; without it LDAC_N is tied high.
module dac_spi_driver #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 4,
   parameter int unsigned LDAC_W   = 2
) (
   input  logic              clk,
   input  logic              nrst,
   dac_spi_driver_if.slave   bus,
   output logic              CS_N,
   output logic              SCLK,
   output logic              SDI,
   output logic              LDAC_N
);

`ifdef DAC_LDAC_EN
   localparam int unsigned GAP_LEN = CS_IDLE + LDAC_W;
`else
   localparam int unsigned GAP_LEN = CS_IDLE;
`endif
   localparam int unsigned CNT_W = 16;
   localparam int unsigned BIT_W = $clog2(DATA_W);

   if (DATA_W < 2 || CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 ||
       CS_IDLE < 1 || LDAC_W < 1) begin : g_param_check
      $error("dac_spi_driver: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bitn;
   logic [DATA_W-1:0] shreg;

   // Frame sequencer: every output is registered; cnt times each phase and
   // SCLK itself tells which half of the current bit period is running.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= IDLE;
         cnt           <= '0;
         bitn          <= '0;
         shreg         <= '0;
         CS_N          <= 1'b1;
         SCLK          <= 1'b0;
         SDI           <= 1'b0;
         bus.din_ready <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               bus.din_ready <= 1'b1;
               if (bus.din_valid && bus.din_ready) begin
                  shreg         <= bus.din;
                  SDI           <= bus.din[DATA_W-1];
                  CS_N          <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.din_ready <= 1'b0;
                  cnt           <= CNT_W'(CS_SETUP - 1);
                  state         <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  cnt   <= CNT_W'(CLK_DIV - 1);
                  bitn  <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  cnt <= CNT_W'(CLK_DIV - 1);
                  if (!SCLK) begin
                     SCLK <= 1'b1;
                  end else begin
                     // SDI only moves together with the falling SCLK edge
                     SCLK <= 1'b0;
                     if (bitn == BIT_W'(DATA_W - 1)) begin
                        cnt   <= CNT_W'(CS_HOLD - 1);
                        state <= HOLD;
                     end else begin
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
                        SDI   <= shreg[DATA_W-2];
                        bitn  <= bitn + BIT_W'(1);
                     end
                  end
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  CS_N     <= 1'b1;
                  SDI      <= 1'b0;
                  bus.done <= 1'b1;
                  cnt      <= CNT_W'(GAP_LEN - 1);
                  state    <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  bus.busy      <= 1'b0;
                  bus.din_ready <= 1'b1;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DAC_LDAC_EN
   // LDAC_N low for the LDAC_W cycles following the first gap cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         LDAC_N <= 1'b1;
      end else begin
         LDAC_N <= !(state == GAP && cnt >= CNT_W'(GAP_LEN - LDAC_W));
      end
   end
`else
   assign LDAC_N = 1'b1;
`endif

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: a frame-offset model predicts every output each
// cycle; literal timing and captured-word checks pin the model itself.
module tb_dac_spi_driver;
   localparam int W     = 16;
   localparam int SETUP = 2;
   localparam int DIV   = 2;
   localparam int HOLD  = 2;
   localparam int IDLE  = 4;
   localparam int LW    = 2;
`ifdef DAC_LDAC_EN
   localparam int LEXT  = LW;
`else
   localparam int LEXT  = 0;
`endif
   localparam int SHIFT_LEN = W * 2 * DIV;              // 64
   localparam int CS_LEN    = SETUP + SHIFT_LEN + HOLD;  // 68
   localparam int FR        = CS_LEN + IDLE + LEXT + 1;  // 73 (75 with LDAC)

   logic clk = 1'b0;
   logic nrst;
   logic CS_N, SCLK, SDI, LDAC_N;

   always #5 clk = ~clk;

   dac_spi_driver_if #(.DATA_W(W)) bus ();

   dac_spi_driver #(
      .DATA_W(W), .CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_HOLD(HOLD),
      .CS_IDLE(IDLE), .LDAC_W(LW)
   ) dut (
      .clk(clk), .nrst(nrst), .bus(bus),
      .CS_N(CS_N), .SCLK(SCLK), .SDI(SDI), .LDAC_N(LDAC_N)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: c = index of the current cycle within a frame (1 = first cycle
   // after the accept edge), 0 when idle.
   int             cyc = 0;
   int             c = 0;
   logic           mrdy = 1'b0;
   logic [W-1:0]   mword = '0;
   int             acc_n = 0;
   int             acc_cyc[$];

   initial forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
         c    = 0;
         mrdy = 1'b0;
      end else begin
         cyc++;
         if (c == 0) begin
            if (mrdy && bus.din_valid) begin
               mword = bus.din;
               c     = 1;
               mrdy  = 1'b0;
               acc_n++;
               acc_cyc.push_back(cyc);
            end else begin
               mrdy = 1'b1;
            end
         end else if (c == FR - 1) begin
            c    = 0;
            mrdy = 1'b1;
         end else begin
            c++;
         end
      end
   end

   // Bits seen by the DAC: sampled on each SCLK rise, cleared at CS_N fall
   logic [W-1:0] cap = '0;
   int           rises = 0;
   initial forever begin
      @(posedge SCLK or negedge CS_N);
      if (SCLK) begin
         cap = {cap[W-2:0], SDI};
         rises++;
      end else begin
         cap   = '0;
         rises = 0;
      end
   end

   // Per-cycle compare plus timing recorders
   logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdi = 1'b0, prev_ldac = 1'b1;
   int   fall_cyc = 0, rise_cyc = 0, low_len = 0, hi_len = 0;
   int   done_n = 0, done_cyc = 0;
   int   ldac_cyc = 0, ldac_run = 0, ldac_total = 0;
   initial forever begin
      logic e_cs, e_sclk, e_sdi, e_busy, e_done, e_rdy, e_ldac, sdi_care;
      int   j;
      @(negedge clk);
      e_cs = 1'b1; e_sclk = 1'b0; e_sdi = 1'b0; e_busy = 1'b0;
      e_done = 1'b0; e_rdy = mrdy; e_ldac = 1'b1; sdi_care = 1'b1;
      if (nrst && c > 0) begin
         e_busy = 1'b1;
         e_rdy  = 1'b0;
         if (c <= CS_LEN) e_cs = 1'b0;
         if (c <= SETUP) begin
            e_sdi = mword[W-1];
         end else if (c <= SETUP + SHIFT_LEN) begin
            j      = c - SETUP - 1;
            e_sclk = (j % (2 * DIV)) >= DIV;
            e_sdi  = mword[W - 1 - j / (2 * DIV)];
         end else if (c <= CS_LEN) begin
            sdi_care = 1'b0;
         end
         if (c == CS_LEN + 1) e_done = 1'b1;
         if (c >= CS_LEN + 2 && c < CS_LEN + 2 + LEXT) e_ldac = 1'b0;
      end
      if (!nrst) e_rdy = 1'b0;
      chk("cs_n", CS_N, e_cs);
      chk("sclk", SCLK, e_sclk);
      if (sdi_care) chk("sdi", SDI, e_sdi);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("din_ready", bus.din_ready, e_rdy);
      chk("ldac_n", LDAC_N, e_ldac);
      if (SCLK && prev_sclk) chk("sdi_stable_sclk_high", SDI, prev_sdi);

      if (prev_cs && !CS_N) begin
         fall_cyc = cyc;
         hi_len   = cyc - rise_cyc;
      end
      if (!prev_cs && CS_N && nrst) begin
         rise_cyc = cyc;
         low_len  = cyc - fall_cyc;
      end
      if (bus.done) begin
         done_n++;
         done_cyc = cyc;
      end
      if (!LDAC_N) begin
         if (prev_ldac) begin
            ldac_cyc = cyc;
            ldac_run = 0;
         end
         ldac_run++;
         ldac_total++;
      end
      prev_cs = CS_N; prev_sclk = SCLK; prev_sdi = SDI; prev_ldac = LDAC_N;
   end

   task automatic wait_acc(int n);
      int g = 0;
      while (acc_n < n && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      chk("accept_within_bound", 32'(acc_n >= n), 1);
   endtask

   task automatic wait_done(int n);
      int g = 0;
      while (done_n < n && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      chk("done_within_bound", 32'(done_n >= n), 1);
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      int d_before;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      nrst          = 1'b1;

      // 1: async reset mid-cycle, valid held across release
      #2 nrst = 1'b0;
      #1;
      chk("rst_cs_n", CS_N, 1);
      chk("rst_sclk", SCLK, 0);
      chk("rst_sdi", SDI, 0);
      chk("rst_ldac_n", LDAC_N, 1);
      chk("rst_ready", bus.din_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      bus.din       = 16'hA5C3;
      bus.din_valid = 1'b1;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", bus.din_ready, 1);
      chk("no_accept_on_release", acc_n, 0);

      // 2: single word
      wait_acc(1);
      bus.din_valid = 1'b0;
      wait_done(1);
      chk("word_a5c3", cap, 16'hA5C3);
      chk("rises_a5c3", rises, 16);
      chk("cs_low_len", low_len, 68);
      chk("done_offset", done_cyc - acc_cyc[0], 68);

      // 3: back-to-back with valid held high
      bus.din       = 16'h0000;
      bus.din_valid = 1'b1;
      wait_acc(2);
      bus.din = 16'hFFFF;
      wait_done(2);
      chk("word_0000", cap, 16'h0000);
      wait_acc(3);
      bus.din_valid = 1'b0;
      chk("b2b_accept_spacing", acc_cyc[2] - acc_cyc[1], 73 + LEXT);
      chk("cs_high_gap_min", 32'(hi_len >= IDLE), 1);
      wait_done(3);
      chk("word_ffff", cap, 16'hFFFF);

      // 4: din change and valid pulse while busy
      bus.din       = 16'h8001;
      bus.din_valid = 1'b1;
      wait_acc(4);
      bus.din_valid = 1'b0;
      cycles(9);
      bus.din = 16'h1234;
      cycles(10);
      bus.din_valid = 1'b1;
      cycles(3);
      bus.din_valid = 1'b0;
      wait_done(4);
      chk("word_8001", cap, 16'h8001);
      cycles(10);
      chk("busy_pulse_not_queued", acc_n, 4);
      bus.din_valid = 1'b1;
      wait_acc(5);
      bus.din_valid = 1'b0;
      wait_done(5);
      chk("word_1234", cap, 16'h1234);

      // 5: reset at the 7th SCLK rise
      bus.din       = 16'h5555;
      bus.din_valid = 1'b1;
      wait_acc(6);
      bus.din_valid = 1'b0;
      g = 0;
      while (rises < 7 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("seventh_rise_reached", rises, 7);
      d_before = done_n;
      nrst = 1'b0;
      #1;
      chk("abort_cs_n", CS_N, 1);
      chk("abort_sclk", SCLK, 0);
      chk("abort_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      cycles(80);
      chk("abort_no_done", done_n, d_before);
      bus.din       = 16'hFFFF;
      bus.din_valid = 1'b1;
      wait_acc(7);
      bus.din_valid = 1'b0;
      wait_done(6);
      chk("post_abort_word", cap, 16'hFFFF);
      chk("post_abort_rises", rises, 16);

      // 6: LDAC pulse and next-accept spacing
      bus.din       = 16'h00FF;
      bus.din_valid = 1'b1;
      wait_acc(8);
      bus.din = 16'h0000;
      wait_done(7);
      chk("word_00ff", cap, 16'h00FF);
      wait_acc(9);
      bus.din_valid = 1'b0;
      chk("ldac_accept_spacing", acc_cyc[8] - acc_cyc[7], FR);
`ifdef DAC_LDAC_EN
      chk("ldac_offset", ldac_cyc - acc_cyc[7], 69);
      chk("ldac_width", ldac_run, LW);
`else
      chk("ldac_never_low", ldac_total, 0);
`endif
      wait_done(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
